// File: rtl/prg_saver.sv
// prg_saver: snapshots the PET BASIC program area over the DMA port and
// streams it out as a .PRG image (2-byte little-endian load address, then
// the program bytes from start..end-1).
// Optional build macro: PRG_SAVE_SUM_EN adds an 8-bit running sum of the
// program bytes accepted by the sink (header excluded).
module prg_saver #(
  parameter logic [15:0] PTR_START  = 16'h0028,
  parameter logic [15:0] PTR_END    = 16'h002A,
  parameter logic [15:0] RAM_LIMIT  = 16'h8000,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_din,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] count
`ifdef PRG_SAVE_SUM_EN
  ,
  output logic [7:0]  sum
`endif
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PTR    = 4'd1;
  localparam logic [3:0] S_CHECK  = 4'd2;
  localparam logic [3:0] S_HDR_LO = 4'd3;
  localparam logic [3:0] S_HDR_HI = 4'd4;
  localparam logic [3:0] S_FETCH  = 4'd5;
  localparam logic [3:0] S_WAITRD = 4'd6;
  localparam logic [3:0] S_SEND   = 4'd7;
  localparam logic [3:0] S_FIN    = 4'd8;

  localparam logic [1:0] LAT = RD_LATENCY[1:0];

  logic [3:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;     // which pointer byte is being read
  logic        pend_q, pend_d;   // pointer read issued, waiting for data
  logic [1:0]  lat_q, lat_d;     // cycles since the read strobe
  logic [15:0] start_q, start_d;
  logic [15:0] end_q, end_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;

  logic accept, lat_hit, last_byte;

  // A byte offered in an abort cycle is never counted as accepted.
  assign accept    = out_valid & out_ready & ~abort;
  assign lat_hit   = (lat_q == LAT);
  assign last_byte = (ptr_q == end_q - 16'd1);

  // Output decode from the state register.
  always_comb begin
    out_valid = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_SEND);
    out_data  = 8'h00;
    case (state_q)
      S_HDR_LO: out_data = start_q[7:0];
      S_HDR_HI: out_data = start_q[15:8];
      S_SEND:   out_data = data_q;
      default:  out_data = 8'h00;
    endcase
    out_last = ((state_q == S_HDR_HI) && (end_q == start_q)) ||
               ((state_q == S_SEND) && last_byte);
    dma_rd   = ((state_q == S_PTR) && !pend_q) || (state_q == S_FETCH);
    busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    done     = (state_q == S_FIN) && !abort;
    error    = err_q;
    count    = count_q;
    dma_addr = addr_q;
  end

  // Next-state logic: pointer fetch, bounds check, header, then one
  // fetch/wait/send round trip per program byte.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    lat_d   = lat_q;
    start_d = start_q;
    end_d   = end_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = accept ? count_q + 16'd1 : count_q;
    err_d   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_PTR;
          idx_d   = 2'd0;
          pend_d  = 1'b0;
          addr_d  = PTR_START;
          count_d = 16'd0;
        end
        S_PTR: begin
          if (!pend_q) begin
            pend_d = 1'b1;
            lat_d  = 2'd1;
          end else if (lat_hit) begin
            pend_d = 1'b0;
            idx_d  = idx_q + 2'd1;
            case (idx_q)
              2'd0: begin start_d[7:0]  = dma_din; addr_d = PTR_START + 16'd1; end
              2'd1: begin start_d[15:8] = dma_din; addr_d = PTR_END; end
              2'd2: begin end_d[7:0]    = dma_din; addr_d = PTR_END + 16'd1; end
              default: begin end_d[15:8] = dma_din; state_d = S_CHECK; end
            endcase
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
        S_CHECK: begin
          if ((end_q < start_q) || (end_q > RAM_LIMIT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_HDR_LO;
          end
        end
        S_HDR_LO: if (accept) state_d = S_HDR_HI;
        S_HDR_HI: if (accept) begin
          if (end_q == start_q) begin
            state_d = S_FIN;
          end else begin
            ptr_d   = start_q;
            addr_d  = start_q;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          lat_d   = 2'd1;
          state_d = S_WAITRD;
        end
        S_WAITRD: begin
          if (lat_hit) begin
            data_d  = dma_din;
            state_d = S_SEND;
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
        S_SEND: if (accept) begin
          if (last_byte) begin
            state_d = S_FIN;
          end else begin
            ptr_d   = ptr_q + 16'd1;
            addr_d  = ptr_q + 16'd1;
            state_d = S_FETCH;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      pend_q  <= 1'b0;
      lat_q   <= 2'd0;
      start_q <= 16'd0;
      end_q   <= 16'd0;
      ptr_q   <= 16'd0;
      addr_q  <= 16'd0;
      data_q  <= 8'd0;
      count_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      lat_q   <= lat_d;
      start_q <= start_d;
      end_q   <= end_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

`ifdef PRG_SAVE_SUM_EN
  logic [7:0] sum_q;

  // Running sum of accepted program bytes, cleared when a save starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= 8'd0;
    end else if (!abort && (state_q == S_IDLE) && start) begin
      sum_q <= 8'd0;
    end else if ((state_q == S_SEND) && accept) begin
      sum_q <= sum_q + data_q;
    end
  end

  assign sum = sum_q;
`endif

endmodule

// File: tb/tb_prg_saver.sv
// tb_prg_saver: scoreboard bench for prg_saver. A RAM model answers DMA
// reads; expected stream bytes are queued when a save is launched and
// popped as the sink accepts them.
module tb_prg_saver;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  dma_din;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy, done, error;
  logic [15:0] count;
`ifdef PRG_SAVE_SUM_EN
  logic [7:0]  sum;
`endif

  prg_saver #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dma_addr(dma_addr), .dma_rd(dma_rd), .dma_din(dma_din),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .error(error),
    .count(count)
`ifdef PRG_SAVE_SUM_EN
    , .sum(sum)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // RAM model: data appears exactly LAT cycles after a read strobe, junk otherwise.
  logic [7:0] mem [0:65535];
  logic [7:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= dma_rd ? mem[dma_addr] : 8'hEE;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign dma_din = dpipe[LAT-1];

  logic [8:0] sb [$];
  logic [8:0] exp_b, hold_d;
  logic       hold_v = 1'b0;
  int done_cnt = 0, err_cnt = 0, vld_cnt = 0, rd401 = 0, acc_cnt = 0;
  int acc_base = 0, cyc = 0, rdy_mode = 0;

  // Monitor: scoreboard pops, hold-stability and event counters.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (out_valid) vld_cnt++;
      if (dma_rd && dma_addr == 16'h0401) rd401++;
      if (hold_v && out_valid) chk("hold_stable", {out_last, out_data}, hold_d);
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (sb.size() == 0) chk("extra_byte", 1, 0);
        else begin
          exp_b = sb.pop_front();
          chk("stream_byte", {out_last, out_data}, exp_b);
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = {out_last, out_data};
    end else begin
      hold_v = 1'b0;
    end
  end

  // Sink ready pattern.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = (acc_cnt - acc_base < 2);
      endcase
    end
  end

  task automatic set_ptrs(input logic [15:0] s, input logic [15:0] e);
    mem[16'h0028] = s[7:0]; mem[16'h0029] = s[15:8];
    mem[16'h002A] = e[7:0]; mem[16'h002B] = e[15:8];
  endtask

  task automatic push_exp(input logic [15:0] s, input logic [15:0] e, output logic [7:0] psum);
    logic l;
    psum = 8'h00;
    sb.push_back({1'b0, s[7:0]});
    sb.push_back({(e == s), s[15:8]});
    for (int a = int'(s); a < int'(e); a++) begin
      l = (a == int'(e) - 1);
      sb.push_back({l, mem[a]});
      psum = psum + mem[a];
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_addr"}, dma_addr, 0);
    chk({tag, "_rd"}, dma_rd, 0);
`ifdef PRG_SAVE_SUM_EN
    chk({tag, "_sum"}, sum, 0);
`endif
  endtask

  // One complete save, optionally with a second start while busy.
  task automatic save(input string tag, input logic [15:0] s, input logic [15:0] e, input bit dbl);
    logic [7:0] psum;
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    set_ptrs(s, e);
    push_exp(s, e, psum);
    pulse_start();
    if (dbl) begin
      repeat (12) @(posedge clk);
      pulse_start();
    end
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (done_cnt != d0) ok = 1'b1;
    end
    chk({tag, "_done_seen"}, ok, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_count"}, count, 32'(int'(e) - int'(s) + 2));
`ifdef PRG_SAVE_SUM_EN
    chk({tag, "_sum"}, sum, psum);
`endif
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_count_hold"}, count, 32'(int'(e) - int'(s) + 2));
  endtask

  task automatic bad_ptrs(input string tag, input logic [15:0] s, input logic [15:0] e);
    int e0, v0, d0;
    bit ok;
    e0 = err_cnt; v0 = vld_cnt; d0 = done_cnt; ok = 1'b0;
    set_ptrs(s, e);
    pulse_start();
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (err_cnt != e0) ok = 1'b1;
    end
    chk({tag, "_error_seen"}, ok, 1);
    chk({tag, "_busy"}, busy, 0);
    repeat (3) @(negedge clk);
    chk({tag, "_error_pulses"}, err_cnt - e0, 1);
    chk({tag, "_no_valid"}, vld_cnt - v0, 0);
    chk({tag, "_no_done"}, done_cnt - d0, 0);
    chk({tag, "_count"}, count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, d0;
    bit ok;
    logic [7:0] junk;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0401] = 8'hAA; mem[16'h0402] = 8'hBB;
    mem[16'h0403] = 8'hCC; mem[16'h0404] = 8'hDD;
    for (int i = 0; i < 10; i++) mem[16'h0601 + i] = 8'(i * 37 + 3);
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // basic stream, always ready
`ifdef PRG_SAVE_SUM_EN
    set_ptrs(16'h0401, 16'h0405);
    push_exp(16'h0401, 16'h0405, junk);
    chk("sum_model", junk, 8'h0E);
    sb.delete();
`endif
    save("basic", 16'h0401, 16'h0405, 1'b0);

    // throttled sink plus a start while busy
    rdy_mode = 1;
    save("slow", 16'h0401, 16'h0405, 1'b1);
    rdy_mode = 0;

    // empty program: header only, no data reads
    rd401 = 0;
    save("empty", 16'h0401, 16'h0401, 1'b0);
    chk("empty_no_rd", rd401, 0);

    // illegal pointers
    bad_ptrs("end_lt_start", 16'h0500, 16'h0400);
    bad_ptrs("end_gt_limit", 16'h0401, 16'h8001);

    // start and abort together in idle: abort wins
    v0 = vld_cnt;
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("sa_busy", busy, 0);
    repeat (12) @(negedge clk);
    chk("sa_no_valid", vld_cnt - v0, 0);

    // abort while the third byte is held
    rdy_mode = 2; acc_base = acc_cnt; d0 = done_cnt; ok = 1'b0;
    set_ptrs(16'h0401, 16'h0405);
    push_exp(16'h0401, 16'h0405, junk);
    pulse_start();
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (out_valid && count == 16'd2) ok = 1'b1;
    end
    chk("abort_third_offered", ok, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", count, 2);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    sb.delete();
    rdy_mode = 0;
    save("after_abort", 16'h0401, 16'h0405, 1'b0);

    // reset in the middle of a data fetch
    d0 = done_cnt; ok = 1'b0;
    set_ptrs(16'h0601, 16'h060B);
    push_exp(16'h0601, 16'h060B, junk);
    pulse_start();
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (dma_rd && count == 16'd3) ok = 1'b1;
    end
    chk("rst_fetch_seen", ok, 1);
    #1 reset = 1'b1;
    #1 chk_zero("midreset");
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_no_done", done_cnt - d0, 0);
    save("after_reset", 16'h0601, 16'h060B, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prg_saver.md
Name: prg_saver

Overview:
- Reverse of the PRG loader: snapshots the BASIC program area of PET RAM and emits it as a standard .PRG byte stream for HPS upload.
- Stream format: 2-byte little-endian load address, then program bytes.
- Reads the BASIC start pointer at $28/$29 and the end pointer at $2A/$2B through the DMA port, then reads RAM[start..end-1].
- Sits between pet2001hw's DMA port and the upload-side byte sink.

Parameters:
- PTR_START, 16'h0028, address of the start-of-program pointer (lo, then hi at +1).
- PTR_END, 16'h002A, address of the end-of-program pointer (lo, then hi at +1).
- RAM_LIMIT, 16'h8000, exclusive upper bound for a legal end pointer.
- RD_LATENCY, 1, cycles from dma_rd to valid dma_din; legal range 1..3.

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a save; ignored unless idle.
- abort  in  1  one-cycle request to cancel; returns to idle, no done.
- dma_addr  out  16  RAM read address.
- dma_rd  out  1  one-cycle read strobe.
- dma_din  in  8  RAM read data, valid RD_LATENCY cycles after dma_rd.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the byte when out_valid & out_ready.
- out_last  out  1  marks the final byte of the stream.
- busy  out  1  high from start accept until done, error or abort.
- done  out  1  one-cycle pulse after the last byte is accepted.
- error  out  1  one-cycle pulse when the pointers are illegal.
- count  out  16  number of bytes accepted by the sink in this save, header included.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset mid-save drops the transfer immediately; no done or error pulse.
- States: IDLE, PTR (4 pointer reads), CHECK, HDR_LO, HDR_HI, FETCH, WAITRD, SEND, FIN.
- IDLE:
  - start -> PTR; busy=1; count=0.
  - start while busy is ignored.
- PTR: reads PTR_START, PTR_START+1, PTR_END, PTR_END+1 in that order.
  - One dma_rd per read; the next read is issued only after the previous data is captured.
  - Each read takes RD_LATENCY+1 cycles; 16-bit start and end registers are assembled as lo|hi<<8.
- CHECK, one cycle:
  - end<start or end>RAM_LIMIT -> error pulse, busy=0, IDLE, no bytes emitted.
  - Otherwise -> HDR_LO.
- HDR_LO / HDR_HI:
  - Present start[7:0], then start[15:8], each held until accepted.
  - out_last on HDR_HI only when end==start (empty program).
- FETCH: dma_addr=ptr (init start); dma_rd for one cycle -> WAITRD.
- WAITRD: after RD_LATENCY cycles, capture dma_din into out_data -> SEND.
- SEND:
  - out_valid=1; out_data, out_last and out_valid stay stable until out_ready.
  - out_last=1 when ptr==end-1.
  - On accept: ptr+1. If last -> FIN, else -> FETCH.
- Throughput: at most one data byte per RD_LATENCY+2 cycles; no prefetch.
- FIN: done pulse for one cycle, busy=0, -> IDLE. count holds its final value until the next start.
- count increments on every accepted byte. 16-bit arithmetic; with end≤RAM_LIMIT it cannot overflow.
- abort has priority over all other events in the same cycle:
  - -> IDLE; out_valid=0; busy=0.
  - No done or error pulse.
  - A byte offered in the abort cycle is not counted.
- start and abort together in IDLE: abort wins; the save does not start.
- dma_rd is never asserted outside PTR and FETCH. dma_addr holds its last value when idle.

Optional Feature:
- Macro: PRG_SAVE_SUM_EN.
- When defined:
  - Adds output port sum[7:0]: modulo-256 sum of the program bytes accepted by the sink, header excluded.
  - Cleared on start accept; valid and stable from the done pulse until the next start.
- When undefined: no port, no adder logic; all other behaviour identical.

Test Plan:
- RAM $28=01 $29=04 $2A=05 $2B=04, $0401..$0404=AA BB CC DD; out_ready=1; pulse start -> stream 01 04 AA BB CC DD; out_last only on DD; one done pulse; count=6; with PRG_SAVE_SUM_EN, sum=0x0E.
- Same setup; out_ready toggles 1-of-3 cycles -> identical stream; out_data held stable while out_valid & !out_ready; count=6.
- start=end=$0401 -> stream 01 04 only; out_last on 04; done; count=2; no dma_rd to $0401.
- Pointers start=$0500, end=$0400 -> error pulse; no out_valid; busy low after CHECK. Separately, end=$8001 -> same result.
- Pulse abort while the third byte is held unaccepted -> out_valid=0 next cycle; no done; count=2. New start -> full correct stream.
- Assert reset during a fetch -> all outputs 0 immediately. Release reset and pulse start -> full stream; RD_LATENCY=3 build gives the same bytes.
